// File: rtl/obi_uart_pkg.sv
// Shared definitions for the UART modem-line block.
//   edge_mode_e : per-channel delta mode (which status transitions latch a delta)
//   *_DEF       : default parameter values used by the top and channel modules
package obi_uart_pkg;

    typedef enum logic [1:0] {
        EDGE_ANY      = 2'b00,  // assert or deassert
        EDGE_ASSERT   = 2'b01,  // status 0 -> 1 only
        EDGE_DEASSERT = 2'b10,  // status 1 -> 0 only
        EDGE_OFF      = 2'b11   // never
    } edge_mode_e;

    localparam int unsigned NUM_IN_DEF  = 4;
    localparam int unsigned NUM_OUT_DEF = 4;
    localparam int unsigned NR_SYNC_DEF = 2;
    localparam int unsigned FILT_W_DEF  = 4;

endpackage

// File: rtl/obi_uart_modem_chan.sv
// One modem input channel: synchronizer, debounce filter, edge detect and
// sticky delta flag.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   in_ni           : raw asynchronous pin, active low
//   lb_en_i         : loopback, load filtered level from lb_level_i
//   lb_level_i      : active-low level to load while in loopback
//   filt_len_i      : debounce length L (0 = no filtering)
//   edge_mode_i     : which status transitions set the delta
//   clr_i           : clear the sticky delta
//   status_o        : filtered level, active high
//   delta_o         : sticky change flag
import obi_uart_pkg::*;

module obi_uart_modem_chan #(
    parameter int unsigned NrSyncStages = NR_SYNC_DEF,
    parameter int unsigned FiltWidth    = FILT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_ni,
    input  logic                 lb_en_i,
    input  logic                 lb_level_i,
    input  logic [FiltWidth-1:0] filt_len_i,
    input  logic [1:0]           edge_mode_i,
    input  logic                 clr_i,
    output logic                 status_o,
    output logic                 delta_o
);

    logic [NrSyncStages-1:0] sync_q, sync_d;
    logic [FiltWidth-1:0]    cnt_q, cnt_d;
    logic                    filt_q, filt_d;
    logic                    delta_q, delta_d;
    logic                    sync_lvl, asserted, deasserted, hit;

    always_comb begin
        sync_d[0] = in_ni;
        for (int k = 1; k < NrSyncStages; k++) sync_d[k] = sync_q[k-1];
        sync_lvl = sync_q[NrSyncStages-1];

        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (lb_en_i) begin
            filt_d = lb_level_i;
            cnt_d  = '0;
        end else if (sync_lvl == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= filt_len_i) begin
            // cnt_q holds completed mismatch cycles; this edge ends the
            // (L+1)-th. '>=' keeps it safe when L shrinks mid-count.
            filt_d = sync_lvl;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + FiltWidth'(1);
        end

        // filtered level is active low: 1->0 is an assert
        asserted   = filt_q & ~filt_d;
        deasserted = ~filt_q & filt_d;
        unique case (edge_mode_e'(edge_mode_i))
            EDGE_ANY:      hit = asserted | deasserted;
            EDGE_ASSERT:   hit = asserted;
            EDGE_DEASSERT: hit = deasserted;
            default:       hit = 1'b0;
        endcase

        // a new event wins over a coincident clear
        delta_d = (delta_q & ~clr_i) | hit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            delta_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            delta_q <= delta_d;
        end
    end

    assign status_o = ~filt_q;
    assign delta_o  = delta_q;

endmodule

// File: rtl/obi_uart_modem_multi.sv
// Multi-channel UART modem-line block: debounced modem inputs with sticky
// change flags and interrupt, registered modem outputs, and loopback.
//   clk_i, rst_i : clock, synchronous active-high reset
//   in_ni        : raw modem inputs, active low
//   out_no       : modem output pins, active low (all ones in loopback)
//   out_bits_i   : control-register output bits, active high
//   loopback_i   : route out_bits_i to the input channels internally
//   filt_len_i   : debounce length
//   edge_mode_i  : 2 bits per channel, see edge_mode_e
//   irq_en_i     : per-channel interrupt enable
//   clr_i        : clear all sticky deltas
//   status_o, delta_o, irq_o : filtered levels, sticky deltas, interrupt
import obi_uart_pkg::*;

module obi_uart_modem_multi #(
    parameter int unsigned NumIn        = NUM_IN_DEF,
    parameter int unsigned NumOut       = NUM_OUT_DEF,
    parameter int unsigned NrSyncStages = NR_SYNC_DEF,
    parameter int unsigned FiltWidth    = FILT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumIn-1:0]     in_ni,
    output logic [NumOut-1:0]    out_no,
    input  logic [NumOut-1:0]    out_bits_i,
    input  logic                 loopback_i,
    input  logic [FiltWidth-1:0] filt_len_i,
    input  logic [2*NumIn-1:0]   edge_mode_i,
    input  logic [NumIn-1:0]     irq_en_i,
    input  logic                 clr_i,
    output logic [NumIn-1:0]     status_o,
    output logic [NumIn-1:0]     delta_o,
    output logic                 irq_o
);

    logic [NumOut-1:0] out_q, out_d;

    always_comb begin
        out_d = loopback_i ? '1 : ~out_bits_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) out_q <= '1;
        else       out_q <= out_d;
    end

    assign out_no = out_q;

    for (genvar i = 0; i < NumIn; i++) begin : g_chan
        logic lb_level;
        // channels without a matching output read as deasserted in loopback
        if (i < NumOut) begin : g_lb
            assign lb_level = ~out_bits_i[i];
        end else begin : g_nolb
            assign lb_level = 1'b1;
        end

        obi_uart_modem_chan #(
            .NrSyncStages (NrSyncStages),
            .FiltWidth    (FiltWidth)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .in_ni       (in_ni[i]),
            .lb_en_i     (loopback_i),
            .lb_level_i  (lb_level),
            .filt_len_i  (filt_len_i),
            .edge_mode_i (edge_mode_i[2*i +: 2]),
            .clr_i       (clr_i),
            .status_o    (status_o[i]),
            .delta_o     (delta_o[i])
        );
    end

    assign irq_o = |(delta_o & irq_en_i);

endmodule
